// File: rtl/fnd_scan_mux_pkg.sv
// fnd_pkg: shared defaults and constants for the FND digit scan multiplexer.
//   FND_DIGITS_DEF    default number of display digits
//   FND_DATA_W_DEF    default bits per digit code
//   FND_SCAN_DIV_DEF  default clocks per digit slot
//   FND_SEL_OFF       inactive (all-ones) digit-select level, sliced to DIGITS bits
package fnd_pkg;

    localparam int unsigned FND_DIGITS_DEF   = 4;
    localparam int unsigned FND_DATA_W_DEF   = 4;
    localparam int unsigned FND_SCAN_DIV_DEF = 100000;
    localparam int unsigned FND_DIGITS_MAX   = 8;

    localparam logic [FND_DIGITS_MAX-1:0] FND_SEL_OFF = '1;

endpackage

// File: rtl/fnd_scan_mux_if.sv
// fnd_scan_mux_if: data/control bundle of the FND scan multiplexer.
//   i_digits     packed digit codes, digit k at [k*DATA_W +: DATA_W], digit 0 = units
//   i_dp         decimal point per digit, active-high
//   i_update     one-cycle capture strobe for i_digits/i_dp
//   i_enable     scan enable
//   o_digit_sel  active-low one-hot digit select
//   o_data       code of the selected digit
//   o_dp         decimal point of the selected digit
//   o_scan_idx   current slot index
//   o_frame_done one-cycle pulse when the index wraps to 0
// modport master drives the i_* side, modport slave is the multiplexer.
interface fnd_scan_mux_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DATA_W = 4
) ();

    localparam int unsigned IDX_W = $clog2(DIGITS);

    logic [DIGITS*DATA_W-1:0] i_digits;
    logic [DIGITS-1:0]        i_dp;
    logic                     i_update;
    logic                     i_enable;
    logic [DIGITS-1:0]        o_digit_sel;
    logic [DATA_W-1:0]        o_data;
    logic                     o_dp;
    logic [IDX_W-1:0]         o_scan_idx;
    logic                     o_frame_done;

    modport master (
        output i_digits, i_dp, i_update, i_enable,
        input  o_digit_sel, o_data, o_dp, o_scan_idx, o_frame_done
    );

    modport slave (
        input  i_digits, i_dp, i_update, i_enable,
        output o_digit_sel, o_data, o_dp, o_scan_idx, o_frame_done
    );

endinterface

// File: rtl/fnd_scan_prescaler.sv
// fnd_scan_prescaler: slot-rate prescaler for the FND scan multiplexer.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   enable  count enable; low holds the count at 0
//   tick    high during the cycle the count holds SCAN_DIV-1
module fnd_scan_prescaler #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned           CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fnd_scan_mux.sv
// fnd_scan_mux: time-multiplexed FND digit scanner with frame-synchronous update.
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        fnd_scan_mux_if.slave (digit codes, dp, update, enable in; select/data out)
// Build option: define FND_LEADING_ZERO_BLANK_EN to blank leading-zero digits (digit 0 never).
module fnd_scan_mux
    import fnd_pkg::*;
#(
    parameter int unsigned DIGITS   = FND_DIGITS_DEF,
    parameter int unsigned DATA_W   = FND_DATA_W_DEF,
    parameter int unsigned SCAN_DIV = FND_SCAN_DIV_DEF
) (
    input logic           i_clk,
    input logic           i_reset_n,
    fnd_scan_mux_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF = FND_SEL_OFF[DIGITS-1:0];

    logic tick;
    logic wrap;

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DIGITS*DATA_W-1:0] pend_dig_q, pend_dig_d;
    logic [DIGITS-1:0]        pend_dp_q, pend_dp_d;
    logic [DIGITS*DATA_W-1:0] disp_dig_q, disp_dig_d;
    logic [DIGITS-1:0]        disp_dp_q, disp_dp_d;

    logic [DIGITS-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dp_q, dp_d;
    logic              fd_q;
    logic [DIGITS-1:0] blank_vec;

    fnd_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .enable (bus.i_enable),
        .tick   (tick)
    );

    always_comb begin
        wrap = tick && (idx_q == IDX_LAST);

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        if (bus.i_update) begin
            pend_dig_d = bus.i_digits;
            pend_dp_d  = bus.i_dp;
        end

        // Commit via pend_*_d so an update on the wrap tick lands in this frame.
        disp_dig_d = disp_dig_q;
        disp_dp_d  = disp_dp_q;
        if (wrap) begin
            disp_dig_d = pend_dig_d;
            disp_dp_d  = pend_dp_d;
        end
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    // blank_vec[k]: digit k and every higher digit are zero.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        blank_vec   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            higher_zero  = higher_zero && (disp_dig_d[k*DATA_W +: DATA_W] == '0);
            blank_vec[k] = higher_zero;
        end
    end
`else
    assign blank_vec = '0;
`endif

    // Outputs are registered from next-state so they move with the index.
    always_comb begin
        data_d = disp_dig_d[idx_d*DATA_W +: DATA_W];
        dp_d   = disp_dp_d[idx_d];
        sel_d  = SEL_OFF;
        if (bus.i_enable && !blank_vec[idx_d]) begin
            sel_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
            sel_q      <= SEL_OFF;
            data_q     <= '0;
            dp_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            dp_q       <= dp_d;
            fd_q       <= wrap;
        end
    end

    assign bus.o_digit_sel  = sel_q;
    assign bus.o_data       = data_q;
    assign bus.o_dp         = dp_q;
    assign bus.o_scan_idx   = idx_q;
    assign bus.o_frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// tb_fnd_scan_mux: self-checking bench for fnd_scan_mux (DIGITS=4, DATA_W=4, SCAN_DIV=4).
module tb_fnd_scan_mux;

    localparam int D  = 4;
    localparam int DW = 4;
    localparam int SD = 4;

    logic clk;
    logic rst_n;

    fnd_scan_mux_if #(.DIGITS(D), .DATA_W(DW)) bus ();

    fnd_scan_mux #(
        .DIGITS   (D),
        .DATA_W   (DW),
        .SCAN_DIV (SD)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: slot position, committed and pending digit arrays.
    int m_idx;
    int m_phase;
    int m_pend[D];
    int m_pdp[D];
    int m_disp[D];
    int m_ddp[D];
    logic [3:0] e_sel;
    logic [3:0] e_data;
    logic       e_dp;
    logic [1:0] e_idx;
    logic       e_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_sel(input bit en);
        logic [3:0] s;
        bit blank;
        s = 4'hF;
        blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (m_idx > 0) begin
            blank = 1'b1;
            for (int j = m_idx; j < D; j++) if (m_disp[j] != 0) blank = 1'b0;
        end
`endif
        if (en && !blank) s[m_idx] = 1'b0;
        return s;
    endfunction

    task automatic model_outputs(input bit en, input bit fd);
        e_sel  = model_sel(en);
        e_data = 4'(m_disp[m_idx]);
        e_dp   = m_ddp[m_idx][0];
        e_idx  = 2'(m_idx);
        e_fd   = fd;
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_phase = 0;
        for (int k = 0; k < D; k++) begin
            m_pend[k] = 0; m_pdp[k] = 0; m_disp[k] = 0; m_ddp[k] = 0;
        end
        e_sel = 4'hF; e_data = 4'h0; e_dp = 1'b0; e_idx = 2'd0; e_fd = 1'b0;
    endtask

    task automatic model_edge();
        bit en, adv, wrap;
        en   = bus.i_enable;
        adv  = en && (m_phase == SD - 1);
        m_phase = (en && !adv) ? m_phase + 1 : 0;
        wrap = adv && (m_idx == D - 1);
        if (bus.i_update) begin
            for (int k = 0; k < D; k++) begin
                m_pend[k] = int'((bus.i_digits >> (DW * k)) & 16'hF);
                m_pdp[k]  = int'(bus.i_dp[k]);
            end
        end
        if (wrap) begin
            for (int k = 0; k < D; k++) begin
                m_disp[k] = m_pend[k];
                m_ddp[k]  = m_pdp[k];
            end
        end
        if (adv) m_idx = (m_idx + 1) % D;
        model_outputs(en, wrap);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".sel"},  32'(bus.o_digit_sel),  32'(e_sel));
        chk({tag, ".data"}, 32'(bus.o_data),       32'(e_data));
        chk({tag, ".dp"},   32'(bus.o_dp),         32'(e_dp));
        chk({tag, ".idx"},  32'(bus.o_scan_idx),   32'(e_idx));
        chk({tag, ".fd"},   32'(bus.o_frame_done), 32'(e_fd));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic run_to(input int idx, input int ph);
        int n;
        n = 0;
        while (!(m_idx == idx && m_phase == ph) && n < 64) begin
            cycle("run");
            n++;
        end
        chk("run_to_reached", 32'((m_idx == idx) && (m_phase == ph)), 32'd1);
    endtask

    task automatic update(input logic [15:0] dig, input logic [3:0] dp);
        bus.i_digits = dig;
        bus.i_dp     = dp;
        bus.i_update = 1'b1;
        cycle("upd");
        bus.i_update = 1'b0;
    endtask

    int fd_cnt;

    initial begin
        rst_n        = 1'b1;
        bus.i_digits = '0;
        bus.i_dp     = '0;
        bus.i_update = 1'b0;
        bus.i_enable = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("reset_rel");

        // Commit 0x1234 and walk one full frame.
        bus.i_enable = 1'b1;
        update(16'h1234, 4'b0010);
        run_to(3, 0);
        run_to(0, 0);
        chk("f1234_s0_data", 32'(bus.o_data), 32'h4);
        chk("f1234_s0_sel", 32'(bus.o_digit_sel), 32'hE);
        run_to(1, 0);
        chk("f1234_s1_data", 32'(bus.o_data), 32'h3);
        chk("f1234_s1_dp", 32'(bus.o_dp), 32'h1);
        run_to(2, 0);
        chk("f1234_s2_data", 32'(bus.o_data), 32'h2);
        chk("f1234_s2_sel", 32'(bus.o_digit_sel), 32'hB);
        run_to(3, 0);
        chk("f1234_s3_data", 32'(bus.o_data), 32'h1);
        chk("f1234_s3_sel", 32'(bus.o_digit_sel), 32'h7);
        run_to(0, 0);
        fd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle("frame");
            if (bus.o_frame_done === 1'b1) fd_cnt++;
        end
        chk("fd_per_16", 32'(fd_cnt), 32'd1);

        // Mid-frame update must not disturb the current frame.
        run_to(1, 1);
        update(16'h5678, 4'b0000);
        chk("mid_old_s1", 32'(bus.o_data), 32'h3);
        run_to(3, 0);
        chk("mid_old_s3", 32'(bus.o_data), 32'h1);
        run_to(0, 0);
        chk("mid_new_s0", 32'(bus.o_data), 32'h8);
        run_to(1, 0);
        chk("mid_new_s1", 32'(bus.o_data), 32'h7);

        // Update coincident with the wrap tick goes straight to display.
        run_to(3, SD - 1);
        update(16'h9ABC, 4'b0001);
        chk("wrap_upd_data", 32'(bus.o_data), 32'hC);
        chk("wrap_upd_fd", 32'(bus.o_frame_done), 32'h1);
        chk("wrap_upd_dp", 32'(bus.o_dp), 32'h1);

        // Disable for 10 cycles in slot 2, with a capture while disabled.
        run_to(2, 1);
        bus.i_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) update(16'h4321, 4'b0000);
            else cycle("dis");
        end
        chk("dis_sel", 32'(bus.o_digit_sel), 32'hF);
        chk("dis_idx", 32'(bus.o_scan_idx), 32'h2);
        bus.i_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("reen");
            chk("reen_idx_hold", 32'(bus.o_scan_idx), 32'h2);
        end
        cycle("reen");
        chk("reen_idx_next", 32'(bus.o_scan_idx), 32'h3);
        run_to(0, 0);
        chk("dis_capture", 32'(bus.o_data), 32'h1);

        // Leading-zero case: 0x0045.
        update(16'h0045, 4'b0000);
        run_to(3, 0);
        run_to(2, 0);
`ifdef FND_LEADING_ZERO_BLANK_EN
        chk("lz_s2_sel", 32'(bus.o_digit_sel), 32'hF);
`else
        chk("lz_s2_sel", 32'(bus.o_digit_sel), 32'hB);
`endif
        chk("lz_s2_data", 32'(bus.o_data), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.i_enable = ($urandom_range(0, 9) != 0);
            bus.i_digits = 16'($urandom);
            bus.i_dp     = 4'($urandom);
            bus.i_update = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) bus.i_digits[15:8] = 8'h00;
            cycle("rand");
        end
        bus.i_update = 1'b0;
        bus.i_enable = 1'b1;

        // Reset mid-slot 3 with an uncommitted pending value.
        run_to(3, 1);
        update(16'h7777, 4'b1111);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("post_rst");
            chk("post_rst_idx0", 32'(bus.o_scan_idx), 32'h0);
        end
        cycle("post_rst");
        chk("post_rst_idx1", 32'(bus.o_scan_idx), 32'h1);
        run_to(0, 0);
        chk("post_rst_disp0", 32'(bus.o_data), 32'h0);
        run_to(1, 0);
        chk("post_rst_disp1", 32'(bus.o_data), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
